// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multi-cycle MIPS control unit:
//   - state_e      : FSM state encoding (also exported on the debug `state` port)
//   - OP_*         : primary opcode values (IR[31:26])
//   - alu_op_e     : ALUOp encoding        (0 add, 1 sub, 2 funct)
//   - alu_src_b_e  : ALUSrcB mux encoding  (0 B, 1 four, 2 sign-ext imm, 3 imm<<2)
//   - pc_source_e  : PCSource mux encoding (0 ALU, 1 ALUOut, 2 jump)
//   - op_class_t   : one-hot instruction class produced by opcode_classifier
//   - ctrl_t       : bundle of every datapath control output
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_source_e;

  // Exactly one bit set for a legal opcode, all zero otherwise.
  typedef struct packed {
    logic rtype;
    logic mem;
    logic branch;
    logic jump;
    logic addi;
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/opcode_classifier.sv
// -----------------------------------------------------------------------------
// opcode_classifier
// Combinational opcode decode for the DECODE state's next-state logic.
// Parameters:
//   ENABLE_BNE  : 0 makes opcode 0x05 illegal
//   ENABLE_ADDI : 0 makes opcode 0x08 illegal
// Ports:
//   opcode   in  6 : IR[31:26]
//   op_class out   : one-hot instruction class (all zero when illegal)
//   illegal  out 1 : opcode not supported in this configuration
// -----------------------------------------------------------------------------
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_BNE  = 1'b1,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_RTYPE:     op_class.rtype  = 1'b1;
      OP_LW, OP_SW: op_class.mem    = 1'b1;
      OP_BEQ:       op_class.branch = 1'b1;
      OP_BNE:       op_class.branch = ENABLE_BNE;
      OP_J:         op_class.jump   = 1'b1;
      OP_ADDI:      op_class.addi   = ENABLE_ADDI;
      default:      op_class        = '0;
    endcase
    illegal = (op_class == '0);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Moore-style control FSM for the multi-cycle MIPS datapath. Each instruction
// walks FETCH -> DECODE -> (execute / memory / write-back) -> FETCH.
// Parameters:
//   MEM_HANDSHAKE : 1 = FETCH/MEM_READ/MEM_WRITE wait for mem_ready,
//                   0 = single-cycle memory, mem_ready ignored
//   ENABLE_BNE    : 0 decodes opcode 0x05 as illegal
//   ENABLE_ADDI   : 0 decodes opcode 0x08 as illegal
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   opcode[5:0]              : IR[31:26], sampled in DECODE
//   mem_ready                : memory access completes this cycle
//   pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
//   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b[1:0], alu_op[1:0], pc_source[1:0] : datapath controls
//   illegal_op               : pulse in the ILLEGAL state
//   instr_done               : pulse in each instruction's last state
//   state[3:0]               : current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_BNE    = 1'b1,
  parameter bit ENABLE_ADDI   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  op_class_t  op_class;
  logic       op_illegal;
  logic       mem_done;
  ctrl_t      ctrl;

  opcode_classifier #(
    .ENABLE_BNE (ENABLE_BNE),
    .ENABLE_ADDI(ENABLE_ADDI)
  ) u_classifier (
    .opcode  (opcode),
    .op_class(op_class),
    .illegal (op_illegal)
  );

  // Without a handshake every memory access finishes in its first cycle.
  assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_done) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_illegal)           state_d = ST_ILLEGAL;
        else if (op_class.rtype)  state_d = ST_EXEC;
        else if (op_class.mem)    state_d = ST_MEM_ADDR;
        else if (op_class.branch) state_d = ST_BRANCH;
        else if (op_class.jump)   state_d = ST_JUMP;
        else                      state_d = ST_ADDI_EXEC;
      end
      // Only lw and sw reach MEM_ADDR, so the latched opcode picks one of two.
      ST_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_done) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_done) state_d = ST_FETCH;
      ST_EXEC:      state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB, ST_ILLEGAL:
                    state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) opcode_q <= opcode;
    end
  end

  // Outputs are decoded from the registered state rather than registered
  // themselves: FETCH/MEM_WRITE strobes depend on mem_ready in the same cycle,
  // and everything must drop to zero in the very cycle rst is high.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_done;
        ctrl.pc_write  = mem_done;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_done;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode_q == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (rst) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign instr_done    = ctrl.instr_done;
  assign state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Two control units driven independently:
//   unit 0 : MEM_HANDSHAKE=1, ENABLE_BNE=1, ENABLE_ADDI=1
//   unit 1 : MEM_HANDSHAKE=0, ENABLE_BNE=0, ENABLE_ADDI=0
// A per-unit stimulus thread issues instructions and queues the expected
// control word for every cycle; a monitor pops and compares on each negedge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_v [2];
  logic [5:0] opc_v [2];
  logic       rdy_v [2];
  obs_t       obs   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, instr_done;
    logic [3:0] state;

    multicycle_control_unit #(
      .MEM_HANDSHAKE(bit'(g == 0)),
      .ENABLE_BNE   (bit'(g == 0)),
      .ENABLE_ADDI  (bit'(g == 0))
    ) dut (
      .clk          (clk),
      .rst          (rst_v[g]),
      .opcode       (opc_v[g]),
      .mem_ready    (rdy_v[g]),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .branch_ne    (branch_ne),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .pc_source    (pc_source),
      .illegal_op   (illegal_op),
      .instr_done   (instr_done),
      .state        (state)
    );

    assign obs[g] = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op, instr_done, state};
  end

  // Scoreboard
  obs_t  q0 [$];
  obs_t  q1 [$];
  string n0 [$];
  string n1 [$];
  int    vectors    = 0;
  int    miscompares = 0;

  int    cyc      [2];
  int    abort_at [2];
  bit    aborted  [2];

  function automatic void push(input int u, input obs_t e, input string nm);
    if (u == 0) begin q0.push_back(e); n0.push_back(nm); end
    else        begin q1.push_back(e); n1.push_back(nm); end
  endfunction

  function automatic void check(input int u, input obs_t a, input obs_t e, input string nm);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL u%0d %s: got %h, expected %h (state got %0d exp %0d)",
               u, nm, a, e, a.state, e.state);
    end
  endfunction

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, obs[0], q0.pop_front(), n0.pop_front());
    if (q1.size() > 0) check(1, obs[1], q1.pop_front(), n1.pop_front());
  end

  function automatic obs_t z(input state_e s);
    obs_t o = '0;
    o.state = s;
    return o;
  endfunction

  // One clock cycle of stimulus. op < 0 drives a random opcode so that the
  // unit is shown to ignore IR outside DECODE.
  task automatic play(input int u, input logic r, input obs_t e, input string nm, input int op);
    if (aborted[u]) return;
    @(posedge clk);
    #1;
    if (cyc[u] == abort_at[u]) begin
      rst_v[u] = 1'b1;
      rdy_v[u] = 1'($urandom);
      opc_v[u] = 6'($urandom);
      push(u, '0, "abort_rst");
      aborted[u] = 1'b1;
    end else begin
      rst_v[u] = 1'b0;
      rdy_v[u] = r;
      opc_v[u] = (op < 0) ? 6'($urandom) : 6'(op);
      push(u, e, nm);
    end
    cyc[u]++;
  endtask

  // Instruction-level reference: fw/mw are the wait cycles in FETCH and in
  // the data access; abort >= 0 raises rst in that cycle of the instruction.
  task automatic run_instr(input int u, input logic [5:0] op, input int fw, input int mw,
                           input int abort);
    bit   hs    = (u == 0);
    bit   ebne  = (u == 0);
    bit   eaddi = (u == 0);
    bit   done_r;
    obs_t e;
    cyc[u]      = 0;
    abort_at[u] = abort;
    aborted[u]  = 1'b0;
    if (!hs) begin fw = 0; mw = 0; end
    // With no handshake, mem_ready is random and must be ignored.
    done_r = hs ? 1'b1 : 1'($urandom);

    for (int i = 0; i < fw; i++) begin
      e = z(ST_FETCH); e.mem_read = 1; e.alu_src_b = 2'd1;
      play(u, 1'b0, e, "fetch_wait", -1);
    end
    e = z(ST_FETCH); e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = 1; e.pc_write = 1;
    play(u, done_r, e, "fetch_done", -1);

    e = z(ST_DECODE); e.alu_src_b = 2'd3;
    play(u, 1'($urandom), e, "decode", int'(op));

    if (op == 6'h00) begin
      e = z(ST_EXEC); e.alu_src_a = 1; e.alu_op = 2'd2;
      play(u, 1'($urandom), e, "r_exec", -1);
      e = z(ST_R_WB); e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
      play(u, 1'($urandom), e, "r_wb", -1);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = z(ST_MEM_ADDR); e.alu_src_a = 1; e.alu_src_b = 2'd2;
      play(u, 1'($urandom), e, "mem_addr", -1);
      if (op == 6'h23) begin
        for (int i = 0; i < mw; i++) begin
          e = z(ST_MEM_READ); e.mem_read = 1; e.i_or_d = 1;
          play(u, 1'b0, e, "lw_wait", -1);
        end
        e = z(ST_MEM_READ); e.mem_read = 1; e.i_or_d = 1;
        play(u, hs ? 1'b1 : 1'($urandom), e, "lw_done", -1);
        e = z(ST_MEM_WB); e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
        play(u, 1'($urandom), e, "lw_wb", -1);
      end else begin
        for (int i = 0; i < mw; i++) begin
          e = z(ST_MEM_WRITE); e.mem_write = 1; e.i_or_d = 1;
          play(u, 1'b0, e, "sw_wait", -1);
        end
        e = z(ST_MEM_WRITE); e.mem_write = 1; e.i_or_d = 1; e.instr_done = 1;
        play(u, hs ? 1'b1 : 1'($urandom), e, "sw_done", -1);
      end
    end else if (op == 6'h04 || (op == 6'h05 && ebne)) begin
      e = z(ST_BRANCH); e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_write_cond = 1;
      e.pc_source = 2'd1; e.branch_ne = (op == 6'h05); e.instr_done = 1;
      play(u, 1'($urandom), e, "branch", -1);
    end else if (op == 6'h02) begin
      e = z(ST_JUMP); e.pc_write = 1; e.pc_source = 2'd2; e.instr_done = 1;
      play(u, 1'($urandom), e, "jump", -1);
    end else if (op == 6'h08 && eaddi) begin
      e = z(ST_ADDI_EXEC); e.alu_src_a = 1; e.alu_src_b = 2'd2;
      play(u, 1'($urandom), e, "addi_exec", -1);
      e = z(ST_ADDI_WB); e.reg_write = 1; e.instr_done = 1;
      play(u, 1'($urandom), e, "addi_wb", -1);
    end else begin
      e = z(ST_ILLEGAL); e.illegal_op = 1;
      play(u, 1'($urandom), e, "illegal", -1);
    end

    if (aborted[u]) begin
      @(posedge clk);
      #1;
      rst_v[u] = 1'b1;
      push(u, '0, "reset_hold");
      aborted[u] = 1'b0;
    end
  endtask

  task automatic unit_thread(input int u);
    logic [5:0] ops [8];
    int         pick, fw, mw, ab;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_v[u] = 1'b1;
      rdy_v[u] = 1'b1;
      push(u, '0, "reset");
    end
    run_instr(u, OP_RTYPE, 0, 0, -1);
    run_instr(u, OP_LW,    0, 2, -1);
    run_instr(u, OP_BNE,   0, 0, -1);
    run_instr(u, OP_BEQ,   1, 0, -1);
    run_instr(u, OP_J,     0, 0, -1);
    run_instr(u, OP_ADDI,  0, 0, -1);
    run_instr(u, OP_SW,    3, 0, -1);
    run_instr(u, OP_SW,    0, 2, 3);
    run_instr(u, 6'h3F,    0, 0, -1);
    repeat (80) begin
      pick = $urandom_range(0, 8);
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 2);
      ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(u, (pick == 8) ? 6'($urandom) : ops[pick], fw, mw, ab);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1;
      opc_v[i] = '0;
      rdy_v[i] = 1'b0;
      cyc[i] = 0;
      abort_at[i] = -1;
      aborted[i] = 1'b0;
    end
    fork
      unit_thread(0);
      unit_thread(1);
    join
    @(negedge clk);
    #1;
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style FSM control unit for the multi-cycle MIPS datapath, replacing the single-cycle combinational decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives all datapath enables and mux selects, and stalls on a memory ready handshake. Parameters select optional instruction support and handshake mode.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = FETCH/MEM_READ/MEM_WRITE wait for `mem_ready`; 0 = memory is single-cycle and `mem_ready` is ignored.
- `ENABLE_BNE`, 1: 0 = opcode 0x05 is decoded as illegal.
- `ENABLE_ADDI`, 1: 0 = opcode 0x08 is decoded as illegal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; sampled only in DECODE.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne` out 1: PC update controls; `branch_ne` inverts the zero test.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write` out 1: memory and IR controls.
- `reg_dst`, `mem_to_reg`, `reg_write`, `alu_src_a` out 1: register-file and ALU-A controls.
- `alu_src_b` out 2: 0 = B, 1 = 4, 2 = sign-ext imm, 3 = imm<<2.
- `alu_op` out 2: 0 = add, 1 = sub, 2 = funct.
- `pc_source` out 2: 0 = ALU, 1 = ALUOut, 2 = jump.
- `illegal_op` out 1: one-cycle pulse on an undecodable opcode.
- `instr_done` out 1: one-cycle pulse in each instruction's last state.
- `state` out 4: current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, ILLEGAL.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0. `ir_write` and `pc_write` assert only in the cycle where the access completes (`mem_ready`=1, or always when `MEM_HANDSHAKE`=0). The FSM then moves to DECODE; otherwise it holds.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target precompute). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 and 0x2B → MEM_ADDR
  - 0x04 and 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EXEC
  - anything else, or a disabled opcode → ILLEGAL
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Goes to MEM_READ for lw, MEM_WRITE for sw, using the opcode latched in DECODE.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Holds until done, then → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. → FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1, held every wait cycle. `instr_done`=1 on the completing cycle, then → FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`=1, `pc_source`=1, `branch_ne` = (latched opcode == 0x05), `instr_done`=1. → FETCH.
- JUMP: `pc_write`=1, `pc_source`=2, `instr_done`=1. → FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. → FETCH.
- ILLEGAL: `illegal_op`=1 and no writes. → FETCH; the PC was already advanced, so the instruction is skipped.
- Outputs not listed for a state are 0.

## Timing
- Reset: `rst`=1 at an edge forces state to FETCH. While `rst` is high, every output is 0, including `pc_write`, `ir_write`, `mem_read`, `mem_write` and `reg_write`.
- The first fetch is issued in the first cycle after `rst` deasserts.
- Reset mid-instruction aborts at the next edge. No partial write-back is issued afterwards.
- Cycles per instruction with zero wait states: R 4, lw 5, sw 4, beq/bne 3, j 3, addi 4, illegal 3.
- Each wait cycle (`mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE) adds one cycle. `mem_read` and `mem_write` stay high for the whole wait.
- `opcode` is latched in DECODE into a 6-bit register. Later changes to IR do not affect the sequence.
- Outputs are pure functions of state, the latched opcode, and `mem_ready` (FETCH/MEM_WRITE gating only).

## Structure
- Package `ctrl_pkg` holds:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module `opcode_classifier` (combinational): takes `opcode` plus the enable parameters and returns a one-hot class plus an illegal flag. It is used by DECODE's next-state logic.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 and an R-type:
  - all outputs are 0 during reset
  - state sequence FETCH, DECODE, EXEC, R_WB
  - `reg_write`=1 and `reg_dst`=1 in cycle 4; `instr_done` pulses once
- lw with `mem_ready` low 2 cycles in MEM_READ: total 7 cycles, `mem_read` high throughout MEM_READ, `reg_write`=1 with `mem_to_reg`=1 only in MEM_WB.
- bne (0x05), `ENABLE_BNE`=1: in BRANCH, `pc_write_cond`=1, `branch_ne`=1, `pc_source`=1, `alu_op`=1.
- bne with `ENABLE_BNE`=0: state goes to ILLEGAL, `illegal_op` pulses 1 cycle, then FETCH, with no write enable asserted.
- FETCH wait of 3 cycles: `ir_write` and `pc_write` assert only on the `mem_ready` cycle, exactly once.
- `rst` asserted during MEM_WRITE: state is FETCH on the next edge, and `mem_write` is 0 from the reset cycle onward.
